// File: rtl/mcm_filter_sched_if.sv
// Handshake and MCM-operand bundle for mcm_filter_sched.
// slave: the filter scheduler itself; master: the surrounding system / bench.
interface mcm_filter_sched_if;
    logic               start;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic [7:0]         mcm_x;
    logic signed [15:0] mcm_y1;
    logic signed [15:0] mcm_y2;
    logic signed [15:0] mcm_y3;
    logic signed [15:0] mcm_y4;
    logic               out_valid;
    logic [7:0]         out_data;
    logic               out_ready;
    logic               busy;
    logic               done;

    modport slave (
        input  start, in_valid, in_data, mcm_y1, mcm_y2, mcm_y3, mcm_y4, out_ready,
        output in_ready, mcm_x, out_valid, out_data, busy, done
    );

    modport master (
        output start, in_valid, in_data, mcm_y1, mcm_y2, mcm_y3, mcm_y4, out_ready,
        input  in_ready, mcm_x, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/mcm_filter_sched.sv
// 4-tap prediction filter scheduler. Slides a 4-sample window over the
// reference stream and time-multiplexes one shared MCM block (taps -3,-2,12,4)
// over 4 MAC cycles per output, then rounds, shifts by 6 and clips to 8 bits.
module mcm_filter_sched #(
    parameter int unsigned N_OUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mcm_filter_sched_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LOAD,
        S_MAC,
        S_OUT
    } state_t;

    localparam logic [4:0] LAST = 5'(N_OUT - 1);

    state_t             state;
    state_t             state_nx;
    logic [7:0]         w0, w1, w2, w3;
    logic [1:0]         k;
    logic [1:0]         fill_cnt;
    logic [4:0]         cnt;
    logic signed [17:0] acc;
    logic [7:0]         out_q;
    logic               done_q;

    logic               in_ready;
    logic               accept;
    logic               out_fire;
    logic [7:0]         x_sel;
    logic signed [15:0] y_sel;
    logic signed [17:0] y_ext;
    logic signed [17:0] acc_sum;
    logic signed [17:0] rounded;
    logic signed [17:0] shifted;
    logic [7:0]         clipped;

    assign in_ready = (state == S_FILL) || (state == S_LOAD);
    assign accept   = bus.in_valid && in_ready;
    assign out_fire = (state == S_OUT) && bus.out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus.start) state_nx = S_FILL;
            S_FILL: if (accept && fill_cnt == 2'd2) state_nx = S_LOAD;
            S_LOAD: if (accept) state_nx = S_MAC;
            S_MAC:  if (k == 2'd3) state_nx = S_OUT;
            S_OUT:  if (bus.out_ready) state_nx = (cnt == LAST) ? S_IDLE : S_LOAD;
            default: state_nx = S_IDLE;
        endcase
    end

    // Window tap fed to the shared multiplier; zero outside MAC.
    always_comb begin
        x_sel = '0;
        if (state == S_MAC) begin
            case (k)
                2'd0:    x_sel = w0;
                2'd1:    x_sel = w1;
                2'd2:    x_sel = w2;
                default: x_sel = w3;
            endcase
        end
    end

    // Product for the current tap, and the rounded/clipped result of the
    // final accumulation (registered on the last MAC edge, so it includes tap 3).
    always_comb begin
        case (k)
            2'd0:    y_sel = bus.mcm_y1;
            2'd1:    y_sel = bus.mcm_y2;
            2'd2:    y_sel = bus.mcm_y3;
            default: y_sel = bus.mcm_y4;
        endcase
        y_ext   = {{2{y_sel[15]}}, y_sel};
        acc_sum = acc + y_ext;
        rounded = acc_sum + 18'sd32;
        shifted = rounded >>> 6;
        if (shifted[17])              clipped = '0;
        else if (shifted > 18'sd255)  clipped = '1;
        else                          clipped = shifted[7:0];
    end

    // Sample window: shifts one position on every accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0 <= '0;
            w1 <= '0;
            w2 <= '0;
            w3 <= '0;
        end else if (accept) begin
            w0 <= w1;
            w1 <= w2;
            w2 <= w3;
            w3 <= bus.in_data;
        end
    end

    // Counters, accumulator, output register and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= '0;
            fill_cnt <= '0;
            cnt      <= '0;
            acc      <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    cnt      <= '0;
                    fill_cnt <= '0;
                end
                S_FILL: if (accept) fill_cnt <= fill_cnt + 2'd1;
                S_LOAD: if (accept) begin
                    k   <= '0;
                    acc <= '0;
                end
                S_MAC: begin
                    acc <= acc_sum;
                    k   <= k + 2'd1;
                    if (k == 2'd3) out_q <= clipped;
                end
                S_OUT: if (out_fire) begin
                    if (cnt == LAST) done_q <= 1'b1;
                    else             cnt    <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mcm_x     = x_sel;
    assign bus.out_valid = (state == S_OUT);
    assign bus.out_data  = out_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_mcm_filter_sched.sv
// Bench for mcm_filter_sched: randomized sample streams and handshakes,
// checked against a window/arithmetic prediction model.
module tb_mcm_filter_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   src[$];

    mcm_filter_sched_if bus ();
    mcm_filter_sched_if bus1 ();

    always #5 clk = ~clk;

    // Ideal shared multiplier block for each instance.
    assign bus.mcm_y1  = 16'(-3  * int'(bus.mcm_x));
    assign bus.mcm_y2  = 16'(-2  * int'(bus.mcm_x));
    assign bus.mcm_y3  = 16'(12  * int'(bus.mcm_x));
    assign bus.mcm_y4  = 16'(4   * int'(bus.mcm_x));
    assign bus1.mcm_y1 = 16'(-3  * int'(bus1.mcm_x));
    assign bus1.mcm_y2 = 16'(-2  * int'(bus1.mcm_x));
    assign bus1.mcm_y3 = 16'(12  * int'(bus1.mcm_x));
    assign bus1.mcm_y4 = 16'(4   * int'(bus1.mcm_x));

    mcm_filter_sched #(.N_OUT(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mcm_filter_sched #(.N_OUT(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Prediction from four consecutive samples: weighted sum, round, floor-divide by 64, clip.
    function automatic int ref_out(int a, int b, int c, int d);
        int v, r, q;
        v = -3 * a - 2 * b + 12 * c + 4 * d;
        r = v + 32;
        if (r >= 0) q = r / 64;
        else        q = -((-r + 63) / 64);
        if (q < 0)   q = 0;
        if (q > 255) q = 255;
        return q;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},     bus.busy,      0);
        check({tag, "_in_ready"}, bus.in_ready,  0);
        check({tag, "_out_valid"},bus.out_valid, 0);
        check({tag, "_done"},     bus.done,      0);
        check({tag, "_mcm_x"},    bus.mcm_x,     0);
    endtask

    // One N_OUT=16 block on dut. src must hold 19 samples.
    task automatic run_block(input int gap_pct, input int stall_len, input bit do_reset, input bit poke_start);
        int         exp_q[$];
        int         sidx = 0;
        int         outs = 0;
        int         st = 0;
        int         dones = 0;
        bit         pend = 0;
        bit         rst_arm = 0;
        bit         finished = 0;
        logic [7:0] held = '0;
        for (int i = 0; i < 16; i++)
            exp_q.push_back(ref_out(src[i], src[i+1], src[i+2], src[i+3]));
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (rst_arm) begin
                rst_n = 1'b0;
                bus.in_valid = 1'b0;
                bus.start = 1'b0;
                #1;
                check_quiet("midrst");
                check("midrst_out_data", bus.out_data, 0);
                @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check_quiet("postrst");
                end
                check("midrst_outs", outs, 5);
                return;
            end
            check("done", bus.done, pend);
            if (bus.done === 1'b1) dones++;
            pend = 0;
            if (outs == 16) begin
                finished = 1;
                break;
            end
            bus.start    = poke_start && bus.busy && ($urandom_range(3) == 0);
            bus.in_valid = ($urandom_range(99) >= gap_pct);
            bus.in_data  = (sidx < 19) ? 8'(src[sidx]) : 8'($urandom);
            if (!bus.in_valid) bus.in_data = 8'($urandom);
            if (stall_len > 0 && outs == 2 && bus.out_valid && st < stall_len) begin
                if (st == 0) held = bus.out_data;
                else         check("stall_data", bus.out_data, held);
                check("stall_in_ready", bus.in_ready, 0);
                check("stall_mcm_x", bus.mcm_x, 0);
                bus.out_ready = 1'b0;
                bus.in_valid  = 1'b1;
                st++;
            end else begin
                bus.out_ready = ($urandom_range(3) != 0);
            end
            if (bus.in_valid && bus.in_ready) begin
                sidx++;
                if (do_reset && outs == 5) rst_arm = 1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (outs < 16) check($sformatf("out%0d", outs), bus.out_data, exp_q[outs]);
                else           check("extra_out", bus.out_valid, 0);
                outs++;
                if (outs == 16) pend = 1;
            end
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        if (!finished) begin
            fails++;
            $error("FAIL timeout: got %0d outputs expected 16", outs);
        end
        check("samples", sidx, 19);
        check("outputs", outs, 16);
        check("done_count", dones, 1);
        if (stall_len > 0) check("stall_len", st, stall_len);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("idle_after");
        end
    endtask

    initial begin
        int n1s[4];
        int s;
        bit pend;
        bit fin;

        bus.start = 0;  bus.in_valid = 0;  bus.in_data = '0;  bus.out_ready = 0;
        bus1.start = 0; bus1.in_valid = 0; bus1.in_data = '0; bus1.out_ready = 0;

        // Reset state.
        #12;
        check_quiet("rst");
        check("rst_out_data", bus.out_data, 0);
        check("rst1_busy", bus1.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // N_OUT=1: samples 0,0,100,0 give a single output of 19.
        n1s = '{0, 0, 100, 0};
        s = 0; pend = 0; fin = 0;
        @(negedge clk); bus1.start = 1'b1;
        @(negedge clk); bus1.start = 1'b0; bus1.out_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            check("n1_done", bus1.done, pend);
            if (pend) begin
                fin = 1;
                break;
            end
            bus1.in_valid = 1'b1;
            bus1.in_data  = (s < 4) ? 8'(n1s[s]) : 8'hAA;
            if (bus1.in_valid && bus1.in_ready) s++;
            if (bus1.out_valid && bus1.out_ready) begin
                check("n1_out", bus1.out_data, ref_out(n1s[0], n1s[1], n1s[2], n1s[3]));
                pend = 1;
            end
        end
        bus1.in_valid = 1'b0;
        if (!fin) begin
            fails++;
            $error("FAIL n1_timeout: got no done expected done");
        end
        check("n1_samples", s, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("n1_idle_done", bus1.done, 0);
            check("n1_idle_busy", bus1.busy, 0);
        end

        // All samples 255.
        src.delete();
        for (int i = 0; i < 19; i++) src.push_back(255);
        run_block(0, 0, 0, 0);

        // Repeating 255,255,0,0: exercises negative clip and mid-range windows.
        src.delete();
        for (int i = 0; i < 19; i++) src.push_back(((i % 4) < 2) ? 255 : 0);
        run_block(30, 0, 0, 0);

        // Random data, input gaps, long output stall, start pokes while busy.
        src.delete();
        for (int i = 0; i < 19; i++) src.push_back(int'($urandom_range(255)));
        run_block(40, 10, 0, 1);

        // Reset during MAC of output 5, then a full fresh block.
        src.delete();
        for (int i = 0; i < 19; i++) src.push_back(int'($urandom_range(255)));
        run_block(20, 0, 1, 0);
        src.delete();
        for (int i = 0; i < 19; i++) src.push_back(($urandom_range(1) == 1) ? 255 : int'($urandom_range(40)));
        run_block(10, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
